// File: rtl/sys_defs.sv
// Shared types for the execute-stage functional units: multiply function codes,
// physical-register / ROB index types and the control packet that travels down the multiplier pipeline.
package sys_defs;

    localparam int XLEN       = 32;
    localparam int NUM_STAGES = 4;
    localparam int PRN_W      = 6;
    localparam int ROB_W      = 5;

    typedef logic [PRN_W-1:0] PRN;
    typedef logic [ROB_W-1:0] ROBN;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MULT_FUNC;

    typedef struct packed {
        MULT_FUNC func;
        PRN       dest_prn;
        ROBN      robn;
    } MULT_STAGE_PACKET;

    function automatic logic op1_signed(input MULT_FUNC func);
        return (func == MULH) || (func == MULHSU);
    endfunction

    function automatic logic op2_signed(input MULT_FUNC func);
        return func == MULH;
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One multiplier pipeline stage: folds BITS multiplier bits into the running 2*XLEN sum and
// registers the result together with the op's control packet.
module mult_stage
    import sys_defs::*;
#(
    parameter int XLEN = 32,
    parameter int BITS = 8,
    parameter bit LAST = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  logic                  load,
    input  logic                  prev_valid,
    input  MULT_STAGE_PACKET      prev_pkt,
    input  logic [2*XLEN-1:0]     prev_mcand,
    input  logic [XLEN-1:0]       prev_mplier,
    input  logic                  prev_neg,
    input  logic [2*XLEN-1:0]     prev_sum,
    output logic                  valid,
    output MULT_STAGE_PACKET      pkt,
    output logic [2*XLEN-1:0]     mcand,
    output logic [XLEN-1:0]       mplier,
    output logic                  neg,
    output logic [2*XLEN-1:0]     sum
);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] next_mcand;

    always_comb begin
        // NOTE: blocking assignments in combinational logic describe an ordered adder chain, not state.
        next_mcand = prev_mcand << BITS;
        acc        = prev_sum;
        for (int i = 0; i < BITS; i++) begin
            if (prev_mplier[i]) acc = acc + (prev_mcand << i);
        end
        // After the final shift the multiplicand sits at bit XLEN: undo the weight of a negative op2 sign bit.
        if (LAST && prev_neg) acc = acc - next_mcand;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: datapath registers are reset as well so the result bus reads zero after reset.
            valid  <= 1'b0;
            pkt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            sum    <= '0;
        end else begin
            if (squash)    valid <= 1'b0;
            else if (load) valid <= prev_valid;
            if (load) begin
                pkt    <= prev_pkt;
                mcand  <= next_mcand;
                mplier <= prev_mplier >> BITS;
                neg    <= prev_neg;
                sum    <= acc;
            end
        end
    end

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: operand extension, bubble-collapsing advance chain,
// issue handshake (fu_avail) and high/low result select for the CDB.
module mult_fu
    import sys_defs::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  logic              in_valid,
    input  logic [1:0]        in_func,
    input  logic [XLEN-1:0]   in_op1,
    input  logic [XLEN-1:0]   in_op2,
    input  logic [PRN_W-1:0]  in_dest_prn,
    input  logic [ROB_W-1:0]  in_robn,
    output logic              fu_avail,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_value,
    output logic [PRN_W-1:0]  out_dest_prn,
    output logic [ROB_W-1:0]  out_robn,
    input  logic              cdb_grant
);

    localparam int BITS = XLEN / NUM_STAGES;
    localparam int L    = NUM_STAGES - 1;

    MULT_FUNC          issue_func;
    MULT_STAGE_PACKET  issue_pkt;

    logic [NUM_STAGES-1:0] valid, neg, move;
    MULT_STAGE_PACKET      pkt    [NUM_STAGES];
    logic [2*XLEN-1:0]     mcand  [NUM_STAGES];
    logic [2*XLEN-1:0]     sum    [NUM_STAGES];
    logic [XLEN-1:0]       mplier [NUM_STAGES];

    logic [NUM_STAGES-1:0] src_valid, src_neg;
    MULT_STAGE_PACKET      src_pkt    [NUM_STAGES];
    logic [2*XLEN-1:0]     src_mcand  [NUM_STAGES];
    logic [2*XLEN-1:0]     src_sum    [NUM_STAGES];
    logic [XLEN-1:0]       src_mplier [NUM_STAGES];

    logic open_slot;
    logic [3*XLEN:0] unused_tail;

    assign issue_func = MULT_FUNC'(in_func);
    assign issue_pkt  = '{func: issue_func, dest_prn: in_dest_prn, robn: in_robn};

    // A stage may load when it or any stage downstream is empty, or the CDB drains the tail;
    // this is the bubble-collapsing advance chain written without a bit-to-bit loop.
    always_comb begin
        open_slot = cdb_grant;
        move      = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            open_slot = open_slot | !valid[k];
            move[k]   = open_slot;
        end
    end

    assign fu_avail = move[0];

    always_comb begin
        src_valid[0]  = in_valid;
        src_pkt[0]    = issue_pkt;
        src_mcand[0]  = {{XLEN{op1_signed(issue_func) & in_op1[XLEN-1]}}, in_op1};
        src_mplier[0] = in_op2;
        src_neg[0]    = op2_signed(issue_func) & in_op2[XLEN-1];
        src_sum[0]    = '0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            src_valid[k]  = valid[k-1];
            src_pkt[k]    = pkt[k-1];
            src_mcand[k]  = mcand[k-1];
            src_mplier[k] = mplier[k-1];
            src_neg[k]    = neg[k-1];
            src_sum[k]    = sum[k-1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        mult_stage #(
            .XLEN (XLEN),
            .BITS (BITS),
            .LAST (k == L)
        ) u_stage (
            .clock       (clock),
            .reset       (reset),
            .squash      (squash),
            .load        (move[k]),
            .prev_valid  (src_valid[k]),
            .prev_pkt    (src_pkt[k]),
            .prev_mcand  (src_mcand[k]),
            .prev_mplier (src_mplier[k]),
            .prev_neg    (src_neg[k]),
            .prev_sum    (src_sum[k]),
            .valid       (valid[k]),
            .pkt         (pkt[k]),
            .mcand       (mcand[k]),
            .mplier      (mplier[k]),
            .neg         (neg[k]),
            .sum         (sum[k])
        );
    end

    // The tail stage's shifted operands have no consumer once the product is complete.
    assign unused_tail = {mcand[L], mplier[L], neg[L]};

    assign out_valid    = valid[L];
    assign out_dest_prn = pkt[L].dest_prn;
    assign out_robn     = pkt[L].robn;
    assign out_value    = (pkt[L].func == MUL) ? sum[L][XLEN-1:0] : sum[L][2*XLEN-1:XLEN];

endmodule
